// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue_pkg / issue_queue
//
// Purpose: out-of-order issue queue between rename and the execution units.
// It buffers renamed instructions in age order and keeps a physical-register
// readiness scoreboard. Each cycle it issues the oldest queued instruction
// whose two source operands are both ready. A stalled entry never blocks a
// younger, independent one.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   instruction_i  renamed instruction (op, rs1, rs2, rd as physical tags)
//   valid_i        instruction_i valid
//   ready_i        queue can accept (count != DEPTH)
//   instruction_o  issued instruction (registered)
//   valid_o        instruction_o valid
//   ready_o        execution side accepts instruction_o
//   wb_valid       a result is written back this cycle
//   wb_tag         physical tag being written back
// -----------------------------------------------------------------------------
package issue_queue_pkg;
    localparam int IQ_O_COUNT = 128;
    localparam int IQ_PW      = $clog2(IQ_O_COUNT);

    typedef struct packed {
        logic [7:0]       op;
        logic [IQ_PW-1:0] rs1;
        logic [IQ_PW-1:0] rs2;
        logic [IQ_PW-1:0] rd;
    } instruction_renamed_t;

    typedef struct packed {
        instruction_renamed_t instr;
        logic                 s1_rdy;
        logic                 s2_rdy;
    } iq_entry_t;
endpackage

module issue_queue
    import issue_queue_pkg::*;
#(
    // Tag fields inside instruction_renamed_t are sized from IQ_O_COUNT, so
    // O_COUNT must match the package value.
    parameter int O_COUNT = IQ_O_COUNT,
    parameter int DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  instruction_renamed_t         instruction_i,
    input  logic                         valid_i,
    output logic                         ready_i,
    output instruction_renamed_t         instruction_o,
    output logic                         valid_o,
    input  logic                         ready_o,
    input  logic                         wb_valid,
    input  logic [$clog2(O_COUNT)-1:0]   wb_tag
);
    localparam int PW = $clog2(O_COUNT);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    iq_entry_t              entry_q [DEPTH];
    iq_entry_t              entry_d [DEPTH];
    iq_entry_t              wake    [DEPTH];
    logic [CW-1:0]          count_q, count_d;
    logic [O_COUNT-1:0]     rdy_q, rdy_d;
    instruction_renamed_t   out_instr_q, out_instr_d;
    logic                   valid_q, valid_d;

    logic                   wb_hit;
    logic                   advance;
    logic                   enq;
    logic                   issue;
    logic                   sel_found;
    logic [IW-1:0]          sel_idx;
    logic [CW-1:0]          ins_pos;
    iq_entry_t              new_entry;

    assign ready_i       = (count_q != CW'(DEPTH));
    assign instruction_o = out_instr_q;
    assign valid_o       = valid_q;

    // Selection looks at the registered ready bits only: a wakeup arriving in
    // the same cycle becomes visible one cycle later, and a newly enqueued
    // instruction is not yet in entry_q.
    always_comb begin
        wb_hit    = wb_valid && (wb_tag != '0);
        advance   = !valid_q || ready_o;
        enq       = valid_i && ready_i;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count_q) && entry_q[i].s1_rdy && entry_q[i].s2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
        issue   = advance && sel_found;
        ins_pos = count_q - CW'(issue);

        // Sources read the scoreboard before this instruction's own rd is
        // marked busy, with the current writeback bypassed in.
        new_entry.instr  = instruction_i;
        new_entry.s1_rdy = rdy_q[instruction_i.rs1] || (wb_valid && (wb_tag == instruction_i.rs1));
        new_entry.s2_rdy = rdy_q[instruction_i.rs2] || (wb_valid && (wb_tag == instruction_i.rs2));
    end

    // Per-slot wakeup and compaction: slots at or above the issued index take
    // their younger neighbour; the new instruction lands just past the last
    // surviving entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic      shift;
        logic      ins_here;
        iq_entry_t kept;

        always_comb begin
            wake[gi]        = entry_q[gi];
            wake[gi].s1_rdy = entry_q[gi].s1_rdy || (wb_hit && (entry_q[gi].instr.rs1 == wb_tag));
            wake[gi].s2_rdy = entry_q[gi].s2_rdy || (wb_hit && (entry_q[gi].instr.rs2 == wb_tag));
        end

        assign shift    = issue && (IW'(gi) >= sel_idx);
        assign ins_here = enq && (CW'(gi) == ins_pos);

        if (gi < DEPTH - 1) begin : g_mid
            assign kept = shift ? wake[gi + 1] : wake[gi];
        end else begin : g_last
            // Top slot becomes vacant on a shift; its stale content is
            // beyond count and never looked at.
            assign kept = wake[gi];
        end

        assign entry_d[gi] = ins_here ? new_entry : kept;
    end

    always_comb begin
        count_d     = count_q + CW'(enq) - CW'(issue);
        out_instr_d = out_instr_q;
        valid_d     = valid_q;
        if (advance) begin
            valid_d = issue;
            if (issue) begin
                out_instr_d = entry_q[sel_idx].instr;
            end
        end

        // Busy-marking is applied after the writeback so that a same-cycle
        // enqueue of the same rd (a younger producer) wins.
        rdy_d = rdy_q;
        if (wb_hit) begin
            rdy_d[wb_tag] = 1'b1;
        end
        if (enq && (instruction_i.rd != '0)) begin
            rdy_d[instruction_i.rd] = 1'b0;
        end
        rdy_d[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q     <= '0;
            rdy_q       <= '1;
            out_instr_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q     <= count_d;
            rdy_q       <= rdy_d;
            out_instr_q <= out_instr_d;
            valid_q     <= valid_d;
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
//
// Self-checking bench for issue_queue: a directed table of per-cycle vectors,
// hand-written fill/stall and mid-run reset sequences, and a randomized run.
// Every cycle the DUT is compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;

    logic                 clk;
    logic                 reset;
    instruction_renamed_t instruction_i;
    logic                 valid_i;
    logic                 ready_i;
    instruction_renamed_t instruction_o;
    logic                 valid_o;
    logic                 ready_o;
    logic                 wb_valid;
    logic [IQ_PW-1:0]     wb_tag;

    issue_queue #(.O_COUNT(IQ_O_COUNT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .instruction_i (instruction_i),
        .valid_i       (valid_i),
        .ready_i       (ready_i),
        .instruction_o (instruction_o),
        .valid_o       (valid_o),
        .ready_o       (ready_o),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        instruction_renamed_t ins;
        bit                   s1;
        bit                   s2;
    } m_entry_t;

    m_entry_t             m_q[$];
    bit [IQ_O_COUNT-1:0]  m_rdy;
    bit                   m_vo;
    instruction_renamed_t m_out;
    bit                   m_known = 0;

    function automatic instruction_renamed_t mk(input int op, input int rs1, input int rs2, input int rd);
        instruction_renamed_t r;
        r.op  = 8'(op);
        r.rs1 = IQ_PW'(rs1);
        r.rs2 = IQ_PW'(rs2);
        r.rd  = IQ_PW'(rd);
        return r;
    endfunction

    task automatic model_update(input bit rst, input bit vi, input instruction_renamed_t ins,
                                input bit ro, input bit wbv, input logic [IQ_PW-1:0] wbt);
        bit       adv;
        bit       acc;
        int       sel;
        m_entry_t ne;
        if (rst) begin
            m_q.delete();
            m_rdy   = '1;
            m_vo    = 0;
            m_out   = '0;
            m_known = 1;
            return;
        end
        adv = !m_vo || ro;
        acc = vi && (m_q.size() != DEPTH);
        sel = -1;
        for (int i = 0; i < m_q.size(); i++) begin
            if (sel < 0 && m_q[i].s1 && m_q[i].s2) sel = i;
        end
        ne.ins = ins;
        ne.s1  = m_rdy[ins.rs1] || (wbv && wbt == ins.rs1);
        ne.s2  = m_rdy[ins.rs2] || (wbv && wbt == ins.rs2);
        if (wbv && wbt != 0) begin
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_q[i].ins.rs1 == wbt) m_q[i].s1 = 1;
                if (m_q[i].ins.rs2 == wbt) m_q[i].s2 = 1;
            end
            m_rdy[wbt] = 1;
        end
        if (adv) begin
            if (sel >= 0) begin
                m_out = m_q[sel].ins;
                m_vo  = 1;
                m_q.delete(sel);
            end else begin
                m_vo = 0;
            end
        end
        if (acc) begin
            m_q.push_back(ne);
            if (ins.rd != 0) m_rdy[ins.rd] = 0;
        end
        m_rdy[0] = 1;
    endtask

    // Called at the negedge: drive, compare current outputs with the model,
    // advance the model, then wait for the next negedge.
    task automatic step(input bit rst, input bit vi, input instruction_renamed_t ins,
                        input bit ro, input bit wbv, input logic [IQ_PW-1:0] wbt);
        reset         = rst;
        valid_i       = vi;
        instruction_i = ins;
        ready_o       = ro;
        wb_valid      = wbv;
        wb_tag        = wbt;
        #1;
        if (m_known) begin
            check("valid_o", valid_o, m_vo);
            check("instruction_o", instruction_o, m_out);
            check("ready_i", ready_i, m_q.size() != DEPTH);
            check("count", dut.count_q, m_q.size());
            check("scoreboard", dut.rdy_q, m_rdy);
        end
        model_update(rst, vi, ins, ro, wbv, wbt);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit                   vi;
        instruction_renamed_t ins;
        bit                   wbv;
        int                   wbt;
        bit                   exp_vo;
        int                   exp_op;
        int                   busy_tag;   // nonzero: that tag must read busy now
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input bit vi, input instruction_renamed_t ins, input bit wbv,
                                 input int wbt, input bit exp_vo, input int exp_op, input int busy_tag);
        vec_t v;
        v.vi = vi; v.ins = ins; v.wbv = wbv; v.wbt = wbt;
        v.exp_vo = exp_vo; v.exp_op = exp_op; v.busy_tag = busy_tag;
        return v;
    endfunction

    initial begin
        instruction_renamed_t z;
        int                   sent;
        int                   got[$];
        z = '0;

        reset = 1; valid_i = 0; instruction_i = '0; ready_o = 0; wb_valid = 0; wb_tag = '0;
        @(negedge clk);
        step(1, 0, z, 0, 0, 0);
        step(1, 0, z, 0, 0, 0);

        // reset state
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_ready_i", ready_i, 1'b1);
        check("rst_instr_o", instruction_o, '0);
        check("rst_count", dut.count_q, 0);
        check("rst_rdy_all", &dut.rdy_q, 1'b1);

        // dependency, out-of-order, bypass and busy-wins scenarios
        tbl.push_back(row(1, mk(1, 0, 0, 5),   0, 0,  0, 0, 0));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 5));
        tbl.push_back(row(0, z,                0, 0,  1, 1, 5));
        tbl.push_back(row(0, z,                1, 5,  0, 0, 0));
        tbl.push_back(row(1, mk(2, 0, 0, 7),   0, 0,  0, 0, 0));
        tbl.push_back(row(1, mk(3, 7, 0, 8),   0, 0,  0, 0, 7));
        tbl.push_back(row(0, z,                0, 0,  1, 2, 7));
        tbl.push_back(row(0, z,                1, 7,  0, 0, 0));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 8));
        tbl.push_back(row(0, z,                1, 8,  1, 3, 0));
        tbl.push_back(row(1, mk(5, 0, 0, 9),   0, 0,  0, 0, 0));
        tbl.push_back(row(1, mk(4, 9, 0, 10),  0, 0,  0, 0, 9));
        tbl.push_back(row(1, mk(6, 0, 0, 11),  0, 0,  1, 5, 10));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 0));
        tbl.push_back(row(0, z,                1, 9,  1, 6, 0));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 0));
        tbl.push_back(row(0, z,                1, 10, 1, 4, 0));
        tbl.push_back(row(1, mk(7, 0, 0, 12),  1, 11, 0, 0, 0));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 12));
        tbl.push_back(row(1, mk(8, 12, 0, 13), 1, 12, 1, 7, 0));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 13));
        tbl.push_back(row(0, z,                1, 13, 1, 8, 0));
        tbl.push_back(row(1, mk(9, 0, 0, 20),  1, 20, 0, 0, 0));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 20));
        tbl.push_back(row(0, z,                1, 20, 1, 9, 0));
        tbl.push_back(row(0, z,                0, 0,  0, 0, 0));

        for (int r = 0; r < tbl.size(); r++) begin
            check("tbl_valid_o", valid_o, tbl[r].exp_vo);
            if (tbl[r].exp_vo) check("tbl_op", instruction_o.op, tbl[r].exp_op);
            if (tbl[r].busy_tag != 0) check("tbl_busy", dut.rdy_q[tbl[r].busy_tag], 1'b0);
            $display("row %0d: valid_o=%0b op=%0d", r, valid_o, instruction_o.op);
            step(0, tbl[r].vi, tbl[r].ins, 1, tbl[r].wbv, IQ_PW'(tbl[r].wbt));
        end

        // fill while stalled; a held valid_i must survive full
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            bit acc;
            acc = (sent < 10) && (m_q.size() != DEPTH);
            step(0, sent < 10, mk(50 + sent, 0, 0, 0), 0, 0, 0);
            if (acc) sent++;
        end
        check("full_ready_i", ready_i, 1'b0);
        check("full_count", dut.count_q, DEPTH);
        check("stall_op", instruction_o.op, 50);
        $display("fill: accepted=%0d ready_i=%0b", sent, ready_i);
        for (int c = 0; c < 16; c++) begin
            bit acc;
            if (valid_o) got.push_back(int'(instruction_o.op));
            acc = (sent < 10) && (m_q.size() != DEPTH);
            step(0, sent < 10, mk(50 + sent, 0, 0, 0), 1, 0, 0);
            if (acc) sent++;
        end
        check("drain_total", got.size(), 10);
        for (int k = 0; k < got.size(); k++) begin
            check("drain_order", got[k], 50 + k);
            $display("issued op=%0d", got[k]);
        end
        check("drain_ready_i", ready_i, 1'b1);

        // reset with entries in flight
        for (int k = 0; k < 5; k++) step(0, 1, mk(60 + k, 0, 0, 30 + k), 0, 0, 0);
        step(1, 0, z, 0, 0, 0);
        check("mid_rst_valid_o", valid_o, 1'b0);
        check("mid_rst_count", dut.count_q, 0);
        check("mid_rst_rdy", &dut.rdy_q, 1'b1);
        step(0, 1, mk(77, 30, 0, 40), 1, 0, 0);
        step(0, 0, z, 1, 0, 0);
        check("post_rst_valid", valid_o, 1'b1);
        check("post_rst_op", instruction_o.op, 77);
        step(0, 0, z, 1, 1, 40);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            instruction_renamed_t ri;
            ri = mk($urandom_range(255), $urandom_range(15), $urandom_range(15), $urandom_range(15));
            step($urandom_range(199) == 0, $urandom_range(9) < 6, ri, $urandom_range(9) < 7,
                 $urandom_range(9) < 5, IQ_PW'($urandom_range(15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
